// File: rtl/prio_encoder_rr.sv
// prio_encoder_rr: N-to-$clog2(N) request encoder with a one-entry output
// register and valid/ready handshakes on both sides.
// Each transaction selects either fixed priority (lowest index wins) or
// round-robin (search starts at a rotating pointer and wraps).
// An all-zero request is reported on none_o.
// Optional feature macro: PRIO_ENCODER_RR_MULTI_CHECK_EN. When it is defined,
// multi_o flags request vectors with more than one bit set. When it is not
// defined, multi_o is tied low.
module prio_encoder_rr #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req_i,
  input  logic         req_valid_i,
  output logic         req_ready_o,
  input  logic         rr_mode_i,
  output logic [W-1:0] enc_o,
  output logic         enc_valid_o,
  input  logic         enc_ready_i,
  output logic         none_o,
  output logic         multi_o
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t       state;
  state_t       state_next;
  logic         in_acc;
  logic         out_acc;
  logic [W-1:0] ptr;
  logic [W-1:0] ptr_next;
  logic [N-1:0] upper;
  logic         rr_hit;
  logic         any;
  logic [W-1:0] winner;

  // Index of the lowest set bit. Returns 0 for an empty vector.
  function automatic logic [W-1:0] lowest(input logic [N-1:0] v);
    logic found;
    lowest = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (v[i] && !found) begin
        lowest = W'(i);
        found  = 1'b1;
      end
    end
  endfunction

  // Valid-bit state register. Reset discards any pending output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= state_next;
  end

  // Next-state logic: fill on input accept, drain on a bare output accept.
  always_comb begin
    state_next = state;
    case (state)
      EMPTY:   if (in_acc) state_next = FULL;
      FULL:    if (out_acc && !in_acc) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  // Handshake outputs. These depend only on the state and on enc_ready_i.
  always_comb begin
    enc_valid_o = (state == FULL);
    req_ready_o = (state != FULL) || enc_ready_i;
    in_acc      = req_valid_i && req_ready_o;
    out_acc     = (state == FULL) && enc_ready_i;
  end

  // Round-robin search as two lowest-bit searches. First look at the
  // requests at or above ptr. If none are set, take the lowest request
  // overall, which is the wrap-around case.
  always_comb begin
    upper = '0;
    for (int unsigned k = 0; k < N; k++) begin
      upper[k] = req_i[k] && (k >= 32'(ptr));
    end
    rr_hit = |upper;
    any    = |req_i;
    winner = (rr_mode_i && rr_hit) ? lowest(upper) : lowest(req_i);
    ptr_next = (winner == LAST) ? '0 : winner + W'(1);
  end

  // Rotating pointer. It advances only on round-robin accepts of nonzero
  // vectors, so switching modes leaves it unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             ptr <= '0;
    else if (in_acc && rr_mode_i && any) ptr <= ptr_next;
  end

  // Output data register. It loads on every input accept and holds
  // through a stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enc_o  <= '0;
      none_o <= 1'b0;
    end else if (in_acc) begin
      enc_o  <= winner;
      none_o <= !any;
    end
  end

`ifdef PRIO_ENCODER_RR_MULTI_CHECK_EN
  logic many;

  // More than one bit is set exactly when clearing the lowest set bit
  // leaves something behind.
  always_comb begin
    many = |(req_i & (req_i - N'(1)));
  end

  // The multi flag is registered alongside the encoded index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         multi_o <= 1'b0;
    else if (in_acc) multi_o <= many;
  end
`else
  assign multi_o = 1'b0;
`endif

endmodule

// File: doc/prio_encoder_rr.md
# prio_encoder_rr

- Parametrised N-to-log2(N) request encoder with a registered output and valid/ready handshakes on both sides.
- Two arbitration modes, selected per transaction:
  - Fixed priority: lowest index wins.
  - Round-robin: a rotating pointer sets the start index.
- Reports an all-zero request explicitly.
- Next-generation replacement for the fixed 8-to-3 encoder; sits between request sources and the arbitration/grant logic of the datapath.

## Interface
Parameters:
- N, default 8: number of request lines; legal range 2..256, any value (power of two not required).
- W, default $clog2(N): encoded index width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock; single clock domain.
- rst  input  1  reset; asynchronous and active-high.
- req_i  input  N  request vector; bit k requests index k.
- req_valid_i  input  1  req_i and rr_mode_i are valid.
- req_ready_o  output  1  block can accept a request this cycle.
- rr_mode_i  input  1  0 = fixed priority, 1 = round-robin; sampled with the request.
- enc_o  output  W  encoded winning index.
- enc_valid_o  output  1  enc_o, none_o and multi_o are valid.
- enc_ready_i  input  1  downstream accepts the output.
- none_o  output  1  accepted request vector was all zero.
- multi_o  output  1  accepted request vector had more than one bit set (see Configuration).

## Operation
- Input accept: req_valid_i && req_ready_o.
- Output accept: enc_valid_o && enc_ready_i.
- req_ready_o = !enc_valid_o || enc_ready_i. This is a single-stage pipeline; back-to-back throughput is 1 request per cycle.
- Fixed mode (rr_mode_i=0): winner is the lowest set index. Example: 8'b0010_1100 -> 2.
- Round-robin mode (rr_mode_i=1):
  - Search ascending from ptr, wrapping from N-1 to 0; the first set bit wins.
  - On accept with a nonzero vector, ptr <= winner+1, wrapping to 0 when winner = N-1.
- ptr behaviour:
  - Reset value 0.
  - Unchanged in fixed mode.
  - Unchanged for zero vectors.
  - Retained across mode switches.
- Zero vector: enc_o=0, none_o=1, multi_o=0; ptr is not updated.
- Nonzero vector: none_o=0.
- Output register on each input accept: loads enc_o, none_o and multi_o; sets enc_valid_o=1.
- Output register otherwise:
  - Output accept without a new input accept clears enc_valid_o.
  - Simultaneous input and output accept reloads the register; enc_valid_o stays 1.
- Output stall: while enc_valid_o && !enc_ready_i, enc_o, none_o and multi_o hold stable. Upstream req_i is ignored (req_ready_o=0).
- An internal FSM is not required beyond the valid bit and ptr. Valid-bit states:
  - EMPTY -> FULL on input accept.
  - FULL -> FULL on stall, or on simultaneous input and output accept.
  - FULL -> EMPTY on output accept without input accept.

## Timing
- Latency: 1 cycle. A request accepted at edge t appears with enc_valid_o=1 after edge t.
- No combinational path from req_i to any output. req_ready_o depends combinationally only on enc_valid_o and enc_ready_i.
- Reset (async assert, takes effect immediately):
  - enc_valid_o=0, enc_o=0, none_o=0, multi_o=0, ptr=0.
  - req_ready_o=1 while in reset.
- Reset mid-transaction: a pending output is discarded and not presented after reset. Deassertion is synchronous to clk externally; the block operates normally on the first edge after deassertion.
- Winner computation: one combinational search across N bits, completed within a single cycle at the target clock for N<=64.

## Configuration
- Macro: PRIO_ENCODER_RR_MULTI_CHECK_EN.
- Defined: multi_o is registered with the output and set to 1 when popcount(req_i)>1 at accept; 0 otherwise.
- Undefined: multi_o is tied to 0 and no popcount logic is synthesised. All other behaviour is identical.

## Test plan
- Reset then fixed mode, N=8, one-hot sweep 8'b0000_0001..8'b1000_0000 with enc_ready_i=1 -> enc_o = 0..7 on consecutive cycles, 1 cycle latency, none_o=0.
- Fixed mode, req_i=8'b1010_0100 -> enc_o=2.
- Fixed mode, req_i=0 -> enc_o=0, none_o=1.
- Fixed mode with macro defined, req_i=8'b1010_0100 -> multi_o=1.
- Round-robin mode, req_i=8'b1000_0101 held for 4 accepts -> enc_o = 0, 2, 7, 0; ptr wraps 7->0.
- Backpressure: enc_ready_i=0 for 3 cycles after an accept -> req_ready_o=0, enc_o stable, no ptr change. Release -> next request accepted in the same cycle as the output handshake, enc_valid_o stays 1.
- N=5 round-robin, req_i=5'b10001 -> enc_o = 0, 4, 0. Also check mode switch mid-stream retains ptr.
- Assert rst while enc_valid_o=1 and enc_ready_i=0 -> enc_valid_o=0 immediately; after release ptr=0, and the first round-robin request 8'b1000_0001 -> enc_o=0.
